pw_input_cond: RTL

PW_INPUT_COND -- requirements
Module: pw_input_cond

---
 rtl/pw_input_cond.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pw_input_cond.sv
// pw_input_cond: synchronizes the raw enter button and slide switches,
// debounces the button and emits one enter strobe per accepted press,
// together with the switch value that was stable for the whole press window.
module pw_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CHAR_W          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_raw,
  input  logic [CHAR_W-1:0] sw_raw,
  output logic [CHAR_W-1:0] char_out,
  output logic              enter_pulse,
  output logic              btn_level
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Synchronizer stages: only these flops ever look at the raw pins.
  logic              btn_meta_q;
  logic              btn_s_q;
  logic [CHAR_W-1:0] sw_meta_q;
  logic [CHAR_W-1:0] sw_s_q;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CHAR_W-1:0] snapshot_q,  snapshot_d;
  logic [CHAR_W-1:0] char_out_q,  char_out_d;
  logic              enter_pulse_q, enter_pulse_d;
  logic              btn_level_q, btn_level_d;

  // Two-flop synchronizers for the button and every switch bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= {CHAR_W{1'b0}};
      sw_s_q     <= {CHAR_W{1'b0}};
    end else begin
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_s_q     <= sw_meta_q;
    end
  end

  // Debounce FSM next-state, counter, snapshot and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snapshot_d    = snapshot_q;
    char_out_d    = char_out_q;
    enter_pulse_d = 1'b0;
    // The counter saturates at N so it can never wrap back into a short window.
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d    = PRESS_WAIT;
          cnt_d      = CNT_ONE;
          snapshot_d = sw_s_q;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (sw_s_q != snapshot_q) begin
          // Switches moved during the window: restart so the captured
          // character is one that was stable for the full debounce time.
          cnt_d      = CNT_ONE;
          snapshot_d = sw_s_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d       = PRESSED;
          enter_pulse_d = 1'b1;
          char_out_d    = snapshot_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s_q) begin
          // Release bounce: go back to PRESSED silently, no new strobe.
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // FSM state, counter, snapshot and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      snapshot_q    <= {CHAR_W{1'b0}};
      char_out_q    <= {CHAR_W{1'b0}};
      enter_pulse_q <= 1'b0;
      btn_level_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      snapshot_q    <= snapshot_d;
      char_out_q    <= char_out_d;
      enter_pulse_q <= enter_pulse_d;
      btn_level_q   <= btn_level_d;
    end
  end

  assign char_out    = char_out_q;
  assign enter_pulse = enter_pulse_q;
  assign btn_level   = btn_level_q;

endmodule
